// File: rtl/apb_target_decoder.sv
// Registered APB decoder: routes each master transaction to one of four targets
// with a fresh SETUP/ACCESS pair, and ends decode misses or stalled targets with an error.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a master ACCESS phase (psel && penable) to capture
// SETUP    | selected target sees psel=1, penable=0
// ACCESS   | selected target sees psel=1, penable=1; wait for pready or timeout
// COMPLETE | one-cycle pready pulse back to the master with latched prdata/perr
`timescale 1ns/1ps
module apb_target_decoder (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic [31:0] apb_request__paddr,
    input  logic        apb_request__penable,
    input  logic        apb_request__psel,
    input  logic        apb_request__pwrite,
    input  logic [31:0] apb_request__pwdata,
    output logic [31:0] apb_response__prdata,
    output logic        apb_response__pready,
    output logic        apb_response__perr,
    input  logic [31:0] apb_response_t0__prdata,
    input  logic        apb_response_t0__pready,
    input  logic        apb_response_t0__perr,
    input  logic [31:0] apb_response_t1__prdata,
    input  logic        apb_response_t1__pready,
    input  logic        apb_response_t1__perr,
    input  logic [31:0] apb_response_t2__prdata,
    input  logic        apb_response_t2__pready,
    input  logic        apb_response_t2__perr,
    input  logic [31:0] apb_response_t3__prdata,
    input  logic        apb_response_t3__pready,
    input  logic        apb_response_t3__perr,
    output logic [31:0] apb_target__paddr,
    output logic        apb_target__penable,
    output logic        apb_target__pwrite,
    output logic [31:0] apb_target__pwdata,
    output logic [3:0]  apb_target__psel,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETUP    = 2'd1,
        S_ACCESS   = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'd254;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_tmo_cnt, w_tmo_cnt_nxt;
    logic [31:0] r_paddr, w_paddr_nxt;
    logic        r_pwrite, w_pwrite_nxt;
    logic [31:0] r_pwdata, w_pwdata_nxt;
    logic [3:0]  r_psel, w_psel_nxt;
    logic        r_penable, w_penable_nxt;
    logic [31:0] r_prdata, w_prdata_nxt;
    logic        r_perr, w_perr_nxt;
    logic        r_pready, w_pready_nxt;
    logic [7:0]  r_timeout_count, w_timeout_count_nxt;

    logic        w_capture;
    logic        w_hit;
    logic [31:0] w_sel_prdata;
    logic        w_sel_pready;
    logic        w_sel_perr;

    assign w_capture = apb_request__psel && apb_request__penable;
    assign w_hit     = (apb_request__paddr[31:18] == 14'd0);

    // Only the selected target's response is ever looked at.
    always_comb begin
        w_sel_prdata = apb_response_t0__prdata;
        w_sel_pready = apb_response_t0__pready;
        w_sel_perr   = apb_response_t0__perr;
        unique case (r_idx)
            2'd1: begin
                w_sel_prdata = apb_response_t1__prdata;
                w_sel_pready = apb_response_t1__pready;
                w_sel_perr   = apb_response_t1__perr;
            end
            2'd2: begin
                w_sel_prdata = apb_response_t2__prdata;
                w_sel_pready = apb_response_t2__pready;
                w_sel_perr   = apb_response_t2__perr;
            end
            2'd3: begin
                w_sel_prdata = apb_response_t3__prdata;
                w_sel_pready = apb_response_t3__pready;
                w_sel_perr   = apb_response_t3__perr;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_idx_nxt           = r_idx;
        w_tmo_cnt_nxt       = r_tmo_cnt;
        w_paddr_nxt         = r_paddr;
        w_pwrite_nxt        = r_pwrite;
        w_pwdata_nxt        = r_pwdata;
        w_psel_nxt          = r_psel;
        w_penable_nxt       = r_penable;
        w_prdata_nxt        = r_prdata;
        w_perr_nxt          = r_perr;
        w_pready_nxt        = 1'b0;
        w_timeout_count_nxt = r_timeout_count;
        unique case (r_state)
            S_IDLE: begin
                w_psel_nxt    = 4'b0000;
                w_penable_nxt = 1'b0;
                if (w_capture) begin
                    w_paddr_nxt  = apb_request__paddr;
                    w_pwrite_nxt = apb_request__pwrite;
                    w_pwdata_nxt = apb_request__pwdata;
                    w_idx_nxt    = apb_request__paddr[17:16];
                    if (w_hit) begin
                        w_state_nxt = S_SETUP;
                        w_psel_nxt  = 4'b0001 << apb_request__paddr[17:16];
                    end else begin
                        w_state_nxt  = S_COMPLETE;
                        w_prdata_nxt = 32'd0;
                        w_perr_nxt   = 1'b1;
                        w_pready_nxt = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
                w_tmo_cnt_nxt = 8'd0;
            end
            S_ACCESS: begin
                if (w_sel_pready) begin
                    w_state_nxt   = S_COMPLETE;
                    w_prdata_nxt  = w_sel_prdata;
                    w_perr_nxt    = w_sel_perr;
                    w_pready_nxt  = 1'b1;
                    w_psel_nxt    = 4'b0000;
                    w_penable_nxt = 1'b0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt         = S_COMPLETE;
                    w_prdata_nxt        = 32'd0;
                    w_perr_nxt          = 1'b1;
                    w_pready_nxt        = 1'b1;
                    w_psel_nxt          = 4'b0000;
                    w_penable_nxt       = 1'b0;
                    w_timeout_count_nxt = (r_timeout_count == 8'hFF) ?
                                          r_timeout_count : r_timeout_count + 8'd1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                end
            end
            S_COMPLETE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_idx           <= 2'd0;
            r_tmo_cnt       <= 8'd0;
            r_paddr         <= 32'd0;
            r_pwrite        <= 1'b0;
            r_pwdata        <= 32'd0;
            r_psel          <= 4'b0000;
            r_penable       <= 1'b0;
            r_prdata        <= 32'd0;
            r_perr          <= 1'b0;
            r_pready        <= 1'b0;
            r_timeout_count <= 8'd0;
        end else if (clk__enable) begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_tmo_cnt       <= w_tmo_cnt_nxt;
            r_paddr         <= w_paddr_nxt;
            r_pwrite        <= w_pwrite_nxt;
            r_pwdata        <= w_pwdata_nxt;
            r_psel          <= w_psel_nxt;
            r_penable       <= w_penable_nxt;
            r_prdata        <= w_prdata_nxt;
            r_perr          <= w_perr_nxt;
            r_pready        <= w_pready_nxt;
            r_timeout_count <= w_timeout_count_nxt;
        end
    end

    assign apb_response__prdata = r_prdata;
    assign apb_response__pready = r_pready;
    assign apb_response__perr   = r_perr;
    assign apb_target__paddr    = r_paddr;
    assign apb_target__penable  = r_penable;
    assign apb_target__pwrite   = r_pwrite;
    assign apb_target__pwdata   = r_pwdata;
    assign apb_target__psel     = r_psel;
    assign timeout_count        = r_timeout_count;

endmodule

// File: tb/tb_apb_target_decoder.sv
// Randomized scoreboard bench for apb_target_decoder: the driver pushes expected
// responses from an address/wait-state model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_apb_target_decoder;

    logic        clk = 1'b0;
    logic        clk__enable;
    logic        reset_n;
    logic [31:0] m_paddr, m_pwdata;
    logic        m_penable, m_psel, m_pwrite;
    logic [31:0] apb_response__prdata;
    logic        apb_response__pready, apb_response__perr;
    logic [31:0] t_prdata [4];
    logic [3:0]  t_pready, t_perr;
    logic [31:0] apb_target__paddr, apb_target__pwdata;
    logic        apb_target__penable, apb_target__pwrite;
    logic [3:0]  apb_target__psel;
    logic [7:0]  timeout_count;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        miss;
        logic        tmo;
        logic [31:0] prdata;
        logic        perr;
        int          lat;
        int          cap;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc = 0;
    int          tgt_wait = 0;
    int          tc_model = 0;
    logic [31:0] tgt_data = 32'd0;
    logic        tgt_err = 1'b0;

    apb_target_decoder dut (
        .clk                     (clk),
        .clk__enable             (clk__enable),
        .reset_n                 (reset_n),
        .apb_request__paddr      (m_paddr),
        .apb_request__penable    (m_penable),
        .apb_request__psel       (m_psel),
        .apb_request__pwrite     (m_pwrite),
        .apb_request__pwdata     (m_pwdata),
        .apb_response__prdata    (apb_response__prdata),
        .apb_response__pready    (apb_response__pready),
        .apb_response__perr      (apb_response__perr),
        .apb_response_t0__prdata (t_prdata[0]),
        .apb_response_t0__pready (t_pready[0]),
        .apb_response_t0__perr   (t_perr[0]),
        .apb_response_t1__prdata (t_prdata[1]),
        .apb_response_t1__pready (t_pready[1]),
        .apb_response_t1__perr   (t_perr[1]),
        .apb_response_t2__prdata (t_prdata[2]),
        .apb_response_t2__pready (t_pready[2]),
        .apb_response_t2__perr   (t_perr[2]),
        .apb_response_t3__prdata (t_prdata[3]),
        .apb_response_t3__pready (t_pready[3]),
        .apb_response_t3__perr   (t_perr[3]),
        .apb_target__paddr       (apb_target__paddr),
        .apb_target__penable     (apb_target__penable),
        .apb_target__pwrite      (apb_target__pwrite),
        .apb_target__pwdata      (apb_target__pwdata),
        .apb_target__psel        (apb_target__psel),
        .timeout_count           (timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (clk__enable) cyc <= cyc + 1;

    // acc = index of the current ACCESS cycle seen by the selected target
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= 0;
        else if (clk__enable) acc <= (apb_target__penable && apb_target__psel != 4'b0) ? acc + 1 : 0;
    end

    // Unselected targets shout pready/perr with junk data; only the selected one is honest.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            t_pready[i] = 1'b1;
            t_perr[i]   = 1'b1;
            t_prdata[i] = 32'hDEAD_0000 | 32'(i);
            if (apb_target__psel[i] && apb_target__penable) begin
                t_pready[i] = (acc == tgt_wait);
                t_perr[i]   = tgt_err;
                t_prdata[i] = tgt_data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                   input int w, input logic [31:0] data, input logic err, input int cap);
        exp_t e;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        e.cap   = cap;
        e.miss  = (addr >= 32'h0004_0000);
        e.tmo   = !e.miss && (w > 254);
        if (e.miss) begin
            e.lat = 1;       e.prdata = 32'd0; e.perr = 1'b1;
        end else if (e.tmo) begin
            e.lat = 2 + 255; e.prdata = 32'd0; e.perr = 1'b1;
        end else begin
            e.lat = 3 + w;   e.prdata = data;  e.perr = err;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && clk__enable) begin
            if (apb_target__psel != 4'b0000) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL psel_unexpected: got %b expected 0000", apb_target__psel);
                end else begin
                    mon_e = sb[0];
                    chk("target_psel", {28'd0, apb_target__psel},
                        mon_e.miss ? 32'd0 : 32'(1 << ((mon_e.addr / 32'h1_0000) % 4)));
                    chk("target_paddr", apb_target__paddr, mon_e.addr);
                    chk("target_pwrite", {31'd0, apb_target__pwrite}, {31'd0, mon_e.wr});
                    chk("target_pwdata", apb_target__pwdata, mon_e.wdata);
                end
            end else begin
                chk("penable_unselected", {31'd0, apb_target__penable}, 32'd0);
            end
            if (apb_response__pready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pready_spurious: got 1 expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_prdata", apb_response__prdata, mon_e.prdata);
                    chk("resp_perr", {31'd0, apb_response__perr}, {31'd0, mon_e.perr});
                    chk("resp_latency", 32'(cyc - mon_e.cap), 32'(mon_e.lat));
                    if (mon_e.tmo && tc_model < 255) tc_model++;
                    chk("timeout_count", {24'd0, timeout_count}, 32'(tc_model));
                end
            end
        end
    end

    task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int w, input logic [31:0] data, input logic err,
                          input bit drop, input bit freeze);
        bit got;
        tgt_wait  = w;
        tgt_data  = data;
        tgt_err   = err;
        m_paddr   = addr;
        m_pwrite  = wr;
        m_pwdata  = wdata;
        m_psel    = 1'b1;
        m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        sb.push_back(model(addr, wr, wdata, w, data, err, cyc));
        if (freeze) begin
            repeat (2) begin @(posedge clk); #1; end
            clk__enable = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            clk__enable = 1'b1;
        end else if (drop) begin
            @(posedge clk); #1;
            m_psel    = 1'b0;
            m_penable = 1'b0;
        end
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (apb_response__pready && clk__enable) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL txn_no_response: got no pready expected pready for addr %h", addr);
            sb.delete();
        end
        @(posedge clk); #1;
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, {28'd0, apb_target__psel}, 32'd0);
        chk({tag, "_penable"}, {31'd0, apb_target__penable}, 32'd0);
        chk({tag, "_paddr"}, apb_target__paddr, 32'd0);
        chk({tag, "_pwrite"}, {31'd0, apb_target__pwrite}, 32'd0);
        chk({tag, "_pwdata"}, apb_target__pwdata, 32'd0);
        chk({tag, "_pready"}, {31'd0, apb_response__pready}, 32'd0);
        chk({tag, "_prdata"}, apb_response__prdata, 32'd0);
        chk({tag, "_perr"}, {31'd0, apb_response__perr}, 32'd0);
        chk({tag, "_timeout_count"}, {24'd0, timeout_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  idx;
        logic [13:0] hi;
        logic [31:0] addr;
        logic        wr;
        int          w, r;

        clk__enable = 1'b1;
        reset_n     = 1'b0;
        m_paddr     = 32'd0;
        m_pwdata    = 32'd0;
        m_pwrite    = 1'b0;
        m_psel      = 1'b0;
        m_penable   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_txn(32'h0002_0010, 1'b0, 32'd0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0001_0004, 1'b1, 32'h1234_5678, 3, 32'd0, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0004_0000, 1'b0, 32'd0, 0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0000_0020, 1'b0, 32'd0, 254, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0002_0020, 1'b0, 32'd0, 253, 32'h7777_0000, 1'b1, 1'b0, 1'b0);
        do_txn(32'h0003_0000, 1'b0, 32'd0, 1000, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0001_0100, 1'b0, 32'd0, 2, 32'h3333_4444, 1'b0, 1'b0, 1'b1);
        do_txn(32'h0003_0008, 1'b0, 32'd0, 1, 32'h5555_6666, 1'b1, 1'b1, 1'b0);
        do_txn(32'hFFFF_0000, 1'b1, 32'hAAAA_BBBB, 0, 32'd0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 150; k++) begin
            idx  = 2'($urandom_range(0, 3));
            hi   = 14'($urandom_range(1, 16383));
            r    = $urandom_range(0, 99);
            addr = (r < 20) ? {hi, idx, 16'($urandom)} : {14'd0, idx, 16'($urandom)};
            r    = $urandom_range(0, 99);
            w    = (r < 90) ? $urandom_range(0, 5) : (r < 95) ? $urandom_range(253, 254) : 1000;
            wr   = 1'($urandom_range(0, 1));
            do_txn(addr, wr, $urandom, w, wr ? 32'd0 : $urandom, ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        for (int k = 0; k < 256; k++)
            do_txn(32'h0003_0000 | 32'(k), 1'b0, 32'd0, 1000, 32'h9999_9999, 1'b0, 1'b0, 1'b0);

        // Abort a stalled read with reset: everything must clear at once, no response.
        tgt_wait  = 1000;
        tgt_data  = 32'h4444_4444;
        tgt_err   = 1'b0;
        m_paddr   = 32'h0000_0040;
        m_pwrite  = 1'b0;
        m_pwdata  = 32'd0;
        m_psel    = 1'b1;
        m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        sb.push_back(model(32'h0000_0040, 1'b0, 32'd0, 1000, 32'h4444_4444, 1'b0, cyc));
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_psel    = 1'b0;
        m_penable = 1'b0;
        sb.delete();
        tc_model = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_txn(32'h0000_0100, 1'b0, 32'd0, 0, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0);

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
